// File: rtl/runtime_unload_outbound.sv
// Outbound RF unloader: after a start pulse, reads N result words from address 0 and
// streams them over valid/ready with tlast on the final word, then pulses done.
module runtime_unload_outbound #(
  parameter int dwidth_RFadd = 8,
  parameter int dwidth_data  = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [dwidth_RFadd-1:0] num_entry_outbound,
  output logic [dwidth_RFadd-1:0] rd_add_outbound,
  output logic                    rd_en_outbound,
  input  logic [dwidth_data-1:0]  rd_data_outbound,
  output logic [dwidth_data-1:0]  m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {IDLE, ARM, READ, DRAIN, FINISH} state_t;

  state_t                  r_state;
  state_t                  w_stateNext;
  logic [dwidth_RFadd-1:0] r_num;
  logic [dwidth_RFadd-1:0] r_addr;
  logic                    r_inflight;
  logic                    r_inflightLast;
  logic [dwidth_data-1:0]  r_data0;
  logic [dwidth_data-1:0]  r_data1;
  logic                    r_last0;
  logic                    r_last1;
  logic [1:0]              r_count;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_lastAddr;
  logic                    w_rdEn;
  logic [2:0]              w_occ;

  assign m_tvalid        = (r_count != 2'd0);
  assign m_tdata         = r_data0;
  assign m_tlast         = m_tvalid & r_last0;
  assign w_pop           = m_tvalid & m_tready;
  assign w_push          = r_inflight;
  assign w_lastAddr      = (r_addr == (r_num - dwidth_RFadd'(1)));
  // Buffered words plus the read in flight, after this cycle's pop, must leave room
  assign w_occ           = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rdEn          = (r_state == READ) && (w_occ < 3'd2);
  assign rd_en_outbound  = w_rdEn;
  assign rd_add_outbound = r_addr;
  assign busy            = (r_state != IDLE);
  assign done            = (r_state == FINISH);

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:   if (start) w_stateNext = ARM;
      ARM:    if (!start) w_stateNext = (num_entry_outbound == '0) ? FINISH : READ;
      READ:   if (w_rdEn && w_lastAddr) w_stateNext = DRAIN;
      DRAIN:  if (w_pop && m_tlast) w_stateNext = FINISH;
      FINISH: w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_num          <= '0;
      r_addr         <= '0;
      r_inflight     <= 1'b0;
      r_inflightLast <= 1'b0;
    end else begin
      r_state        <= w_stateNext;
      r_inflight     <= w_rdEn;
      r_inflightLast <= w_rdEn && w_lastAddr;
      if (r_state == ARM) begin
        r_addr <= '0;
        if (!start) r_num <= num_entry_outbound;
      end else if (w_rdEn && !w_lastAddr) begin
        r_addr <= r_addr + dwidth_RFadd'(1);
      end
    end
  end

  // Two-entry shift FIFO; slot 0 is always the head presented on the stream
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 2'd0;
      r_data0 <= '0;
      r_data1 <= '0;
      r_last0 <= 1'b0;
      r_last1 <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_data0 <= rd_data_outbound;
            r_last0 <= r_inflightLast;
          end else begin
            r_data1 <= rd_data_outbound;
            r_last1 <= r_inflightLast;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_data0 <= r_data1;
          r_last0 <= r_last1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_data0 <= rd_data_outbound;
            r_last0 <= r_inflightLast;
          end else begin
            r_data0 <= r_data1;
            r_last0 <= r_last1;
            r_data1 <= rd_data_outbound;
            r_last1 <= r_inflightLast;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_runtime_unload_outbound.sv
// Directed bench for runtime_unload_outbound: a behavioural RF returns 0xA0+addr one
// cycle after each strobe; beats, timing, backpressure, reset and start handling are checked.
module tb_runtime_unload_outbound;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  numEntry;
  logic [7:0]  rdAdd;
  logic        rdEn;
  logic [31:0] rdData;
  logic [31:0] tData;
  logic        tValid;
  logic        tReady;
  logic        tLast;
  logic        busy;
  logic        done;

  int totalChecks = 0;
  int badChecks   = 0;

  runtime_unload_outbound #(.dwidth_RFadd(8), .dwidth_data(32)) dut (
    .clk(clk), .rst(rst), .start(start), .num_entry_outbound(numEntry),
    .rd_add_outbound(rdAdd), .rd_en_outbound(rdEn), .rd_data_outbound(rdData),
    .m_tdata(tData), .m_tvalid(tValid), .m_tready(tReady), .m_tlast(tLast),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural RF: data only meaningful the cycle after a strobe, junk otherwise
  always @(posedge clk) rdData <= rdEn ? (32'h0000_00A0 + {24'd0, rdAdd}) : 32'hDEAD_BEEF;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".rdAdd"},  {24'd0, rdAdd}, 32'd0);
    checkOutput({tag, ".rdEn"},   {31'd0, rdEn},  32'd0);
    checkOutput({tag, ".tValid"}, {31'd0, tValid}, 32'd0);
    checkOutput({tag, ".tLast"},  {31'd0, tLast}, 32'd0);
    checkOutput({tag, ".tData"},  tData,          32'd0);
    checkOutput({tag, ".busy"},   {31'd0, busy},  32'd0);
    checkOutput({tag, ".done"},   {31'd0, done},  32'd0);
  endtask

  // Runs one unload of n words. readyMode 0: ready always high; 1: ready 1,0,0,1 repeating.
  // holdCycles: cycles start stays high in ARM. repulse: pulse start again during READ.
  // abortBeats: when nonzero, return right after that many handshakes are seen.
  task automatic applyStimulus(input int n, input int readyMode, input int holdCycles,
                               input bit repulse, input int abortBeats);
    int issued   = 0;
    int beats    = 0;
    int dones    = 0;
    int doneCyc  = -1;
    int validCnt = 0;
    bit prevStall = 0;
    logic [31:0] prevData = '0;
    logic        prevLast = 0;
    numEntry = 8'(n);
    start = 1'b1;
    for (int h = 0; h < holdCycles; h++) begin
      tick();
      checkOutput("armBusy", {31'd0, busy}, 32'd1);
      checkOutput("armNoRead", {31'd0, rdEn}, 32'd0);
    end
    start = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      tick();
      numEntry = 8'hFF;
      if (readyMode == 0) tReady = 1'b1;
      else tReady = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
      if (repulse && cyc == 2) start = 1'b1;
      if (repulse && cyc == 4) start = 1'b0;
      #1;
      if (prevStall) begin
        checkOutput("stallValid", {31'd0, tValid}, 32'd1);
        checkOutput("stallData", tData, prevData);
        checkOutput("stallLast", {31'd0, tLast}, {31'd0, prevLast});
      end
      prevStall = tValid && !tReady;
      prevData  = tData;
      prevLast  = tLast;
      if (tValid) validCnt++;
      if (rdEn) begin
        checkOutput("rdAddr", {24'd0, rdAdd}, 32'(issued));
        if (readyMode == 0) checkOutput("readCycle", 32'(cyc), 32'(1 + issued));
        issued++;
      end
      if (tValid && tReady) begin
        checkOutput("beatData", tData, 32'h0000_00A0 + 32'(beats));
        checkOutput("beatLast", {31'd0, tLast}, {31'd0, (beats == n - 1)});
        if (readyMode == 0) checkOutput("beatCycle", 32'(cyc), 32'(3 + beats));
        beats++;
      end
      checkOutput("occupancy", {31'd0, ((issued - beats) <= 2)}, 32'd1);
      if (n == 0) checkOutput("zeroBusy", {31'd0, busy}, {31'd0, (cyc == 1)});
      if (done) begin
        dones++;
        doneCyc = cyc;
        checkOutput("doneAfterBeats", 32'(beats), 32'(n));
      end
      if (abortBeats > 0 && beats == abortBeats) return;
      if (dones > 0 && cyc >= doneCyc + 2) break;
    end
    checkOutput("doneCount", 32'(dones), 32'd1);
    checkOutput("beatCount", 32'(beats), 32'(n));
    checkOutput("readCount", 32'(issued), 32'(n));
    if (readyMode == 0) checkOutput("doneCycle", 32'(doneCyc), (n == 0) ? 32'd1 : 32'(3 + n));
    if (n == 0) checkOutput("zeroValid", 32'(validCnt), 32'd0);
    checkOutput("idleAfter", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    numEntry = 8'd0;
    tReady = 1'b1;
    tick();
    tick();
    checkResetOutputs("reset");
    rst = 1'b0;
    tick();

    $display("[TB] N=4 with ready high");
    applyStimulus(4, 0, 1, 1'b0, 0);
    $display("[TB] N=8 with ready toggling");
    applyStimulus(8, 1, 1, 1'b0, 0);
    $display("[TB] N=1");
    applyStimulus(1, 0, 1, 1'b0, 0);
    $display("[TB] N=0");
    applyStimulus(0, 0, 1, 1'b0, 0);

    $display("[TB] reset after third beat of N=6");
    applyStimulus(6, 0, 1, 1'b0, 3);
    rst = 1'b1;
    tick();
    checkResetOutputs("midReset");
    rst = 1'b0;
    tick();
    checkOutput("postResetValid", {31'd0, tValid}, 32'd0);
    tick();
    checkOutput("postResetIdle", {31'd0, busy}, 32'd0);
    applyStimulus(2, 0, 1, 1'b0, 0);

    $display("[TB] long start hold and re-pulse during READ");
    applyStimulus(4, 0, 10, 1'b1, 0);
    tick();
    checkOutput("noSecondRun", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
